// File: rtl/sync_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
// Shared types and helpers for the synchroniser/debouncer slice.
//   chan_state_e : per-channel filter state (STABLE / PENDING)
//   cnt_width()  : qualification counter width for a given FILTER_CYCLES
// -----------------------------------------------------------------------------
package sync_pkg;

    // STABLE  : filtered level agrees with the synchronised level, counter idle.
    // PENDING : a new level has been seen and is being qualified.
    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } chan_state_e;

    // Counter must hold values 0..FILTER_CYCLES without wrapping.
    function automatic int cnt_width(input int filter_cycles);
        if (filter_cycles < 1) begin
            return 1;
        end
        return $clog2(filter_cycles + 1);
    endfunction

endpackage : sync_pkg

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
// Single-channel debounce filter. The already-synchronised level must disagree
// with the current filtered level on FILTER_CYCLES consecutive enabled samples
// before it is accepted. A one-cycle rise/fall pulse is registered alongside
// the filtered output, so it is high in the first cycle the new level shows.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   sync_i       : synchronised channel level
//   sample_en_i  : sample strobe; qualification only advances when high
//   filt_o       : debounced level
//   rise_o       : one-cycle pulse on filt_o 0->1
//   fall_o       : one-cycle pulse on filt_o 1->0
// -----------------------------------------------------------------------------
module debounce_chan
    import sync_pkg::*;
#(
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    input  logic sample_en_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CW       = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

    chan_state_e   r_state;
    logic [CW-1:0] r_cnt;
    logic          r_filt;
    logic          r_rise;
    logic          r_fall;

    logic          w_mismatch;

    assign w_mismatch = (sync_i != r_filt);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_filt  <= RESET_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                ST_STABLE: begin
                    if (w_mismatch && sample_en_i) begin
                        if (FILTER_CYCLES == 1) begin
                            // Single-sample filter: this sample is the whole
                            // qualification, accept now.
                            r_filt <= sync_i;
                            r_rise <= sync_i;
                            r_fall <= ~sync_i;
                            r_cnt  <= '0;
                        end else begin
                            r_state <= ST_PENDING;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                end
                ST_PENDING: begin
                    if (!w_mismatch) begin
                        // Input bounced back: abandon qualification, whatever
                        // the strobe says.
                        r_state <= ST_STABLE;
                        r_cnt   <= '0;
                    end else if (sample_en_i) begin
                        if (r_cnt == CNT_LAST) begin
                            r_filt  <= sync_i;
                            r_rise  <= sync_i;
                            r_fall  <= ~sync_i;
                            r_cnt   <= '0;
                            r_state <= ST_STABLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    // Mismatch without strobe: hold count and state.
                end
                default: begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign filt_o = r_filt;
    assign rise_o = r_rise;
    assign fall_o = r_fall;

endmodule : debounce_chan

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
// WIDTH independent channels, each: a private PIPE_LENGTH-flop synchroniser
// chain followed by a debounce_chan filter.
//
// Ports
//   dest_clk_i   : sole clock, rising edge
//   rst_i        : asynchronous active-high reset
//   sig_i        : asynchronous channel inputs [WIDTH]
//   sample_en_i  : filter sample strobe (tie high to filter every cycle)
//   sync_sig_o   : raw synchronised level, last chain stage [WIDTH]
//   filt_sig_o   : debounced level [WIDTH]
//   rise_o       : one-cycle pulse on filt_sig_o 0->1 [WIDTH]
//   fall_o       : one-cycle pulse on filt_sig_o 1->0 [WIDTH]
// -----------------------------------------------------------------------------
module sync_debounce
    import sync_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               PIPE_LENGTH   = 2,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             dest_clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sig_i,
    input  logic             sample_en_i,
    output logic [WIDTH-1:0] sync_sig_o,
    output logic [WIDTH-1:0] filt_sig_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        // Chain owned by this channel only; stage 0 is the metastability
        // capture flop, stage PIPE_LENGTH-1 drives the filter.
        logic [PIPE_LENGTH-1:0] r_chain;

        always_ff @(posedge dest_clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_chain <= {PIPE_LENGTH{RESET_VALUE[g]}};
            end else begin
                r_chain <= {r_chain[PIPE_LENGTH-2:0], sig_i[g]};
            end
        end

        assign sync_sig_o[g] = r_chain[PIPE_LENGTH-1];

        debounce_chan #(
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_LEVEL   (RESET_VALUE[g])
        ) u_chan (
            .clk_i       (dest_clk_i),
            .rst_i       (rst_i),
            .sync_i      (r_chain[PIPE_LENGTH-1]),
            .sample_en_i (sample_en_i),
            .filt_o      (filt_sig_o[g]),
            .rise_o      (rise_o[g]),
            .fall_o      (fall_o[g])
        );
    end

endmodule : sync_debounce
